// File: rtl/id_hazard_scoreboard_pkg.sv
// Shared definitions for the ID-stage hazard scoreboard.
// Opcodes, producer classes and the counter-width helper.
package id_hazard_scoreboard_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  typedef enum logic [1:0] {
    PROD_ALU    = 2'd0,
    PROD_LOAD   = 2'd1,
    PROD_MULDIV = 2'd2
  } prod_e;

  // Counter width able to hold the largest producer latency plus headroom.
  function automatic int cnt_w(input int lus, input int brx);
    return $clog2(lus + brx + 2);
  endfunction

endpackage

// File: rtl/hazard_reg_counter.sv
// Per-register readiness down-counter.
// A load overrides the free-running decrement.
module hazard_reg_counter #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_val,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Reload on a new producer, otherwise count down to zero.
  always_ff @(posedge clk) begin
    if (rst)
      r_cnt <= '0;
    else if (i_load)
      r_cnt <= i_val;
    else if (r_cnt != '0)
      r_cnt <= r_cnt - 1'b1;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/id_hazard_scoreboard.sv
// ID-stage hazard unit built on a per-register ready scoreboard.
// Tracks ALU, load and decoupled mul/div producers.
module id_hazard_scoreboard
  import id_hazard_scoreboard_pkg::*;
#(
  parameter int NUM_REGS       = 32,
  parameter int LOAD_USE_STALL = 1,
  parameter int BR_EXTRA       = 1,
  parameter int STORE_DATA_FWD = 1,
  parameter int STALL_CNT_W    = 16,
  parameter int REG_W          = $clog2(NUM_REGS)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   id_valid,
  input  logic                   id_is_branch,
  input  logic                   id_is_store,
  input  logic                   id_is_load,
  input  logic                   id_is_muldiv,
  input  logic                   id_uses_rs1,
  input  logic                   id_uses_rs2,
  input  logic [REG_W-1:0]       id_rs1,
  input  logic [REG_W-1:0]       id_rs2,
  input  logic [REG_W-1:0]       id_rd,
  input  logic                   id_reg_write,
  input  logic                   flush,
  input  logic                   muldiv_done,
  output logic                   pc_write,
  output logic                   if_id_write,
  output logic                   ctrl_0_sig,
  output logic                   branch_predictor_enable,
  output logic                   muldiv_busy,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam int CW = cnt_w(LOAD_USE_STALL, BR_EXTRA);
  localparam int NR = 2 ** REG_W;
  localparam logic [CW-1:0] L_ALU = CW'(BR_EXTRA);
  localparam logic [CW-1:0] L_LD  = CW'(LOAD_USE_STALL + BR_EXTRA);

  logic             r_md_pend;
  logic [REG_W-1:0] r_md_rd;
  logic [STALL_CNT_W-1:0] r_sc;

  logic [CW-1:0] w_cnt [NR];
  logic          w_stall;
  logic          w_issue;
  logic          w_wr;
  logic          w_md_fin;
  logic          w_go;
  prod_e         w_cls;
  logic [CW-1:0] w_ival;
  logic [CW-1:0] w_lim1;
  logic [CW-1:0] w_lim2;
  logic          w_sfwd;
  logic          w_hz1;
  logic          w_hz2;
  logic          w_md_hz1;
  logic          w_md_hz2;
  logic          w_struct;

  assign w_issue  = id_valid & ~w_stall & ~flush & ~rst;
  assign w_wr     = w_issue & id_reg_write & (id_rd != '0);
  assign w_md_fin = r_md_pend & muldiv_done;

  assign w_cls = id_is_muldiv ? PROD_MULDIV :
                 id_is_load   ? PROD_LOAD   : PROD_ALU;

  // Latency loaded into the destination counter at issue.
  always_comb begin
    w_ival = '0;
    unique case (w_cls)
      PROD_ALU:    w_ival = L_ALU;
      PROD_LOAD:   w_ival = L_LD;
      PROD_MULDIV: w_ival = '0;
      default:     w_ival = '0;
    endcase
  end

  assign w_cnt[0] = '0;

  for (genvar r = 1; r < NR; r++) begin : g_reg
    if (r < NUM_REGS) begin : g_trk
      logic w_iss_hit;
      logic w_md_hit;
      assign w_iss_hit = w_wr & (id_rd == REG_W'(r));
      assign w_md_hit  = w_md_fin & (r_md_rd == REG_W'(r));
      hazard_reg_counter #(.W(CW)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_iss_hit | w_md_hit),
        .i_val  (w_iss_hit ? w_ival : L_ALU),
        .o_cnt  (w_cnt[r])
      );
    end else begin : g_none
      assign w_cnt[r] = '0;
    end
  end

  assign w_lim1 = id_is_branch ? '0 : L_ALU;
  assign w_sfwd = (STORE_DATA_FWD != 0) & id_is_store &
                  (id_rs2 != id_rs1);
  assign w_lim2 = w_lim1 + CW'(w_sfwd);

  // A finishing mul/div looks like a fresh ALU result this cycle.
  assign w_md_hz1 = r_md_pend & (r_md_rd == id_rs1) &
                    (~muldiv_done | (L_ALU > w_lim1));
  assign w_md_hz2 = r_md_pend & (r_md_rd == id_rs2) &
                    (~muldiv_done | (L_ALU > w_lim2));

  assign w_hz1 = id_uses_rs1 & (id_rs1 != '0) &
                 (w_md_hz1 | (w_cnt[id_rs1] > w_lim1));
  assign w_hz2 = id_uses_rs2 & (id_rs2 != '0) &
                 (w_md_hz2 | (w_cnt[id_rs2] > w_lim2));

  assign w_struct = r_md_pend & ~muldiv_done &
                    (id_is_muldiv |
                     (id_reg_write & (id_rd == r_md_rd)));

  assign w_stall = id_valid & (w_hz1 | w_hz2 | w_struct);
  assign w_go    = ~w_stall & ~rst;

  assign pc_write                = w_go;
  assign if_id_write             = w_go;
  assign ctrl_0_sig              = w_go;
  assign branch_predictor_enable = w_go;
  assign muldiv_busy             = r_md_pend;
  assign stall_count             = r_sc;

  // Mul/div occupancy; a new issue wins over a same-cycle completion.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_md_pend <= 1'b0;
      r_md_rd   <= '0;
    end else if (w_wr & id_is_muldiv) begin
      r_md_pend <= 1'b1;
      r_md_rd   <= id_rd;
    end else if (w_md_fin) begin
      r_md_pend <= 1'b0;
    end
  end

  // Saturating count of stall cycles.
  always_ff @(posedge clk) begin
    if (rst)
      r_sc <= '0;
    else if (w_stall & ~(&r_sc))
      r_sc <= r_sc + 1'b1;
  end

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Self-checking bench for id_hazard_scoreboard.
// Expected stall counts queue at drive time, pop at issue.
module tb_id_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_is_branch, id_is_store;
  logic        id_is_load, id_is_muldiv;
  logic        id_uses_rs1, id_uses_rs2;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_reg_write, flush;
  logic        muldiv_done;
  logic        pc_write, if_id_write, ctrl_0_sig;
  logic        branch_predictor_enable, muldiv_busy;
  logic [15:0] stall_count;

  int checks = 0;
  int failures = 0;
  int tb_cyc = 0;
  int done_at = -1;
  int last_iss = 0;
  int exp_sc = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  assign muldiv_done = (tb_cyc == done_at);

  id_hazard_scoreboard dut (
    .clk                     (clk),
    .rst                     (rst),
    .id_valid                (id_valid),
    .id_is_branch            (id_is_branch),
    .id_is_store             (id_is_store),
    .id_is_load              (id_is_load),
    .id_is_muldiv            (id_is_muldiv),
    .id_uses_rs1             (id_uses_rs1),
    .id_uses_rs2             (id_uses_rs2),
    .id_rs1                  (id_rs1),
    .id_rs2                  (id_rs2),
    .id_rd                   (id_rd),
    .id_reg_write            (id_reg_write),
    .flush                   (flush),
    .muldiv_done             (muldiv_done),
    .pc_write                (pc_write),
    .if_id_write             (if_id_write),
    .ctrl_0_sig              (ctrl_0_sig),
    .branch_predictor_enable (branch_predictor_enable),
    .muldiv_busy             (muldiv_busy),
    .stall_count             (stall_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr_id();
    id_valid     = 1'b0;
    id_is_branch = 1'b0;
    id_is_store  = 1'b0;
    id_is_load   = 1'b0;
    id_is_muldiv = 1'b0;
    id_uses_rs1  = 1'b0;
    id_uses_rs2  = 1'b0;
    id_rs1       = '0;
    id_rs2       = '0;
    id_rd        = '0;
    id_reg_write = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic idle(input int n);
    clr_id();
    repeat (n) tick();
  endtask

  task automatic drive(input bit br, input bit st, input bit ld,
                       input bit md, input bit u1, input bit u2,
                       input int rs1, input int rs2, input int rd,
                       input bit rw, input bit fl);
    id_valid     = 1'b1;
    id_is_branch = br;
    id_is_store  = st;
    id_is_load   = ld;
    id_is_muldiv = md;
    id_uses_rs1  = u1;
    id_uses_rs2  = u2;
    id_rs1       = 5'(rs1);
    id_rs2       = 5'(rs2);
    id_rd        = 5'(rd);
    id_reg_write = rw;
    flush        = fl;
  endtask

  // Hold an instruction in ID until it issues; compare stall cycles.
  task automatic run(input string tag,
                     input bit br, input bit st, input bit ld,
                     input bit md, input bit u1, input bit u2,
                     input int rs1, input int rs2, input int rd,
                     input bit rw, input bit fl, input int exp_st);
    int n;
    bit done;
    n = 0;
    done = 1'b0;
    exp_q.push_back(exp_st);
    exp_sc += exp_st;
    drive(br, st, ld, md, u1, u2, rs1, rs2, rd, rw, fl);
    while (!done && n < 200) begin
      @(negedge clk);
      if (pc_write) begin
        done = 1'b1;
        last_iss = tb_cyc;
      end else begin
        n++;
      end
      tick();
    end
    clr_id();
    chk(tag, 32'(n), 32'(exp_q.pop_front()));
  endtask

  initial begin
    clr_id();
    rst = 1'b1;
    @(negedge clk);
    chk("rst_outs", {28'd0, pc_write, if_id_write,
                     ctrl_0_sig, branch_predictor_enable}, 32'h0);
    tick();
    @(negedge clk);
    chk("rst_busy", {31'd0, muldiv_busy}, 32'd0);
    chk("rst_sc", {16'd0, stall_count}, 32'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_outs", {28'd0, pc_write, if_id_write,
                          ctrl_0_sig, branch_predictor_enable}, 32'hF);
    tick();

    run("lw_x5",    0,0,1,0, 1,0, 2,0,5, 1,0, 0);
    run("add_x5",   0,0,0,0, 1,1, 5,1,6, 1,0, 1);
    chk("sc_loaduse", {16'd0, stall_count}, 32'(exp_sc));
    idle(3);

    run("addi_x7",  0,0,0,0, 1,0, 1,0,7, 1,0, 0);
    run("beq_alu",  1,0,0,0, 1,1, 7,0,0, 0,0, 1);
    idle(3);
    run("lw_x7",    0,0,1,0, 1,0, 2,0,7, 1,0, 0);
    run("beq_ld",   1,0,0,0, 1,1, 7,0,0, 0,0, 2);
    chk("sc_branch", {16'd0, stall_count}, 32'(exp_sc));
    idle(3);

    run("lw_x5b",   0,0,1,0, 1,0, 2,0,5, 1,0, 0);
    run("sw_data",  0,1,0,0, 1,1, 2,5,0, 0,0, 0);
    idle(3);
    run("lw_x5c",   0,0,1,0, 1,0, 2,0,5, 1,0, 0);
    run("sw_addr",  0,1,0,0, 1,1, 5,5,0, 0,0, 1);
    idle(3);

    run("div_x9",   0,0,0,1, 1,1, 1,2,9, 1,0, 0);
    done_at = last_iss + 11;
    run("add_indep",0,0,0,0, 1,1, 1,2,4, 1,0, 0);
    chk("md_busy", {31'd0, muldiv_busy}, 32'd1);
    run("add_dep",  0,0,0,0, 1,1, 9,1,3, 1,0, 9);
    chk("md_idle", {31'd0, muldiv_busy}, 32'd0);
    run("div2_x9",  0,0,0,1, 1,1, 1,2,9, 1,0, 0);
    done_at = last_iss + 5;
    run("mul_struct",0,0,0,1, 1,1, 1,2,10, 1,0, 4);
    done_at = last_iss + 3;
    run("beq_md",   1,0,0,0, 1,1, 10,0,0, 0,0, 4);
    chk("sc_md", {16'd0, stall_count}, 32'(exp_sc));
    idle(3);

    run("lw_x0",    0,0,1,0, 1,0, 2,0,0, 1,0, 0);
    run("add_x0",   0,0,0,0, 1,1, 0,0,6, 1,0, 0);
    run("lw_flush", 0,0,1,0, 1,0, 2,0,8, 1,1, 0);
    run("add_x8",   0,0,0,0, 1,0, 8,0,6, 1,0, 0);
    idle(3);

    run("div_x11",  0,0,0,1, 1,1, 1,2,11, 1,0, 0);
    run("lw_x5d",   0,0,1,0, 1,0, 2,0,5, 1,0, 0);
    chk("pre_rst_busy", {31'd0, muldiv_busy}, 32'd1);
    chk("pre_rst_sc", {16'd0, stall_count}, 32'(exp_sc));
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_outs", {28'd0, pc_write, if_id_write,
                         ctrl_0_sig, branch_predictor_enable}, 32'h0);
    tick();
    rst = 1'b0;
    exp_sc = 0;
    @(negedge clk);
    chk("rst2_outs", {28'd0, pc_write, if_id_write,
                      ctrl_0_sig, branch_predictor_enable}, 32'hF);
    chk("rst2_busy", {31'd0, muldiv_busy}, 32'd0);
    chk("rst2_sc", {16'd0, stall_count}, 32'd0);
    tick();
    run("add_x11",  0,0,0,0, 1,0, 11,0,3, 1,0, 0);
    run("add_x5r",  0,0,0,0, 1,0, 5,0,6, 1,0, 0);

    run("div_x12",  0,0,0,1, 1,1, 1,2,12, 1,0, 0);
    drive(0,0,0,1, 1,1, 1,2,13, 1,0);
    repeat (65540) tick();
    @(negedge clk);
    chk("sat_stall", {31'd0, pc_write}, 32'd0);
    chk("sat_sc", {16'd0, stall_count}, 32'hFFFF);
    done_at = tb_cyc + 1;
    tick();
    @(negedge clk);
    chk("sat_release", {31'd0, pc_write}, 32'd1);
    tick();
    clr_id();
    @(negedge clk);
    chk("sat_hold", {16'd0, stall_count}, 32'hFFFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
